// File: rtl/cache_assoc_pkg.sv
// Shared constants, FSM state encoding and field-width helpers for cache_assoc.
package cache_assoc_pkg;

   // Processor-wide constants the cache is sized from.
   localparam int PROC_ARCH_BITS        = 32;
   localparam int PROC_MEMORY_LINE_BITS = 128;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EVICT = 2'd1,
      FILL  = 2'd2
   } state_t;

   // Ceiling log2; log2(1) = 0.
   function automatic int log2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/cache_assoc_if.sv
// Requester and memory-side signals of cache_assoc. The master drives requests
// and memory responses; the slave is the cache itself.
interface cache_assoc_if
   import cache_assoc_pkg::*;
#(
   parameter int ARCH_BITS = PROC_ARCH_BITS,
   parameter int LINE_BITS = PROC_MEMORY_LINE_BITS
);
   logic [ARCH_BITS-1:0] rAddr;
   logic                 RE;
   logic [ARCH_BITS-1:0] rData;
   logic                 rValid;
   logic [ARCH_BITS-1:0] wAddr;
   logic [ARCH_BITS-1:0] wData;
   logic                 WE;
   logic                 wAck;
   logic [ARCH_BITS-1:0] readMemAddr;
   logic                 readMemReq;
   logic [LINE_BITS-1:0] readMemData;
   logic                 readMemLineValid;
   logic [ARCH_BITS-1:0] writeMemAddr;
   logic [LINE_BITS-1:0] writeMemLine;
   logic                 writeMemReq;
   logic                 writeMemAck;
   logic                 busy;

   modport master (
      output rAddr, RE, wAddr, wData, WE, readMemData, readMemLineValid, writeMemAck,
      input  rData, rValid, wAck, readMemAddr, readMemReq, writeMemAddr, writeMemLine,
             writeMemReq, busy
   );

   modport slave (
      input  rAddr, RE, wAddr, wData, WE, readMemData, readMemLineValid, writeMemAck,
      output rData, rValid, wAck, readMemAddr, readMemReq, writeMemAddr, writeMemLine,
             writeMemReq, busy
   );
endinterface

// File: rtl/cache_plru.sv
// Tree pseudo-LRU for one set: next PLRU bits after a hit, and victim choice
// (lowest invalid way first, otherwise the way the tree points at).
module cache_plru
   import cache_assoc_pkg::*;
#(
   parameter  int WAYS      = 2,
   localparam int WAY_BITS  = (WAYS > 1) ? log2(WAYS) : 1,
   localparam int PLRU_BITS = (WAYS > 1) ? WAYS - 1 : 1
) (
   input  logic [PLRU_BITS-1:0] plru_cur,
   input  logic [WAYS-1:0]      valid,
   input  logic [WAY_BITS-1:0]  hit_way,
   output logic [PLRU_BITS-1:0] plru_next,
   output logic [WAY_BITS-1:0]  victim
);
   logic [WAY_BITS-1:0] tree_way;

   // Bit 0 picks the victim half; bits 1/2 pick within the low/high pair.
   if (WAYS == 4) begin : g_four
      // Point every node on the hit path away from the hit way.
      always_comb begin
         plru_next    = plru_cur;
         plru_next[0] = ~hit_way[1];
         if (hit_way[1]) plru_next[2] = ~hit_way[0];
         else            plru_next[1] = ~hit_way[0];
         tree_way = {plru_cur[0], plru_cur[0] ? plru_cur[2] : plru_cur[1]};
      end
   end else if (WAYS == 2) begin : g_two
      assign plru_next = ~hit_way;
      assign tree_way  = plru_cur;
   end else begin : g_one
      assign plru_next = plru_cur;
      assign tree_way  = '0;
   end

   // Lowest-index invalid way wins over the tree choice.
   always_comb begin
      victim = tree_way;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[w]) victim = WAY_BITS'(w);
      end
   end
endmodule

// File: rtl/cache_assoc.sv
// Set-associative write-back cache with combinational hit path, tree-PLRU
// replacement and an IDLE/EVICT/FILL miss engine.
module cache_assoc
   import cache_assoc_pkg::*;
#(
   parameter int ARCH_BITS       = PROC_ARCH_BITS,
   parameter int CACHE_LINE_SIZE = PROC_MEMORY_LINE_BITS,
   parameter int SETS            = 4,
   parameter int WAYS            = 2
) (
   input logic         clk,
   input logic         rst,
   cache_assoc_if.slave bus
);
   localparam int OFF_BITS  = log2(CACHE_LINE_SIZE / 8);
   localparam int IDX_BITS  = log2(SETS);
   localparam int TAG_BITS  = ARCH_BITS - OFF_BITS - IDX_BITS;
   localparam int BYTE_BITS = log2(ARCH_BITS / 8);
   localparam int WSEL_BITS = OFF_BITS - BYTE_BITS;
   localparam int LADR_BITS = ARCH_BITS - OFF_BITS;
   localparam int WAY_BITS  = (WAYS > 1) ? log2(WAYS) : 1;
   localparam int PLRU_BITS = (WAYS > 1) ? WAYS - 1 : 1;

   logic [CACHE_LINE_SIZE-1:0] line_mem [SETS][WAYS];
   logic [TAG_BITS-1:0]        tag_mem  [SETS][WAYS];
   logic [WAYS-1:0]            valid_q  [SETS];
   logic [WAYS-1:0]            dirty_q  [SETS];
   logic [PLRU_BITS-1:0]       plru_q   [SETS];

   state_t               state_q, state_d;
   logic [LADR_BITS-1:0] miss_line_q, miss_line_d;
   logic [WAY_BITS-1:0]  victim_q, victim_d;
   logic                 start_miss;

   logic [IDX_BITS-1:0]  r_idx, w_idx, m_idx;
   logic [TAG_BITS-1:0]  r_tag, w_tag, m_tag;
   logic [WSEL_BITS-1:0] r_word, w_word;
   logic                 r_hit, w_hit, rd_hit, wr_hit, rd_miss, wr_miss, idle;
   logic [WAY_BITS-1:0]  r_way, w_way, r_victim, w_victim;
   logic [PLRU_BITS-1:0] r_plru_next, w_plru_next;
   logic                 fill_done, evict_done;

   assign r_idx  = bus.rAddr[OFF_BITS +: IDX_BITS];
   assign r_tag  = bus.rAddr[ARCH_BITS-1 -: TAG_BITS];
   assign r_word = bus.rAddr[BYTE_BITS +: WSEL_BITS];
   assign w_idx  = bus.wAddr[OFF_BITS +: IDX_BITS];
   assign w_tag  = bus.wAddr[ARCH_BITS-1 -: TAG_BITS];
   assign w_word = bus.wAddr[BYTE_BITS +: WSEL_BITS];
   assign m_idx  = miss_line_q[IDX_BITS-1:0];
   assign m_tag  = miss_line_q[LADR_BITS-1 -: TAG_BITS];

   // Tag compare across the ways of the read set and of the write set.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      r_hit = 1'b0;
      r_way = '0;
      w_hit = 1'b0;
      w_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[r_idx][w] && tag_mem[r_idx][w] == r_tag) begin
            r_hit = 1'b1;
            r_way = WAY_BITS'(w);
         end
         if (valid_q[w_idx][w] && tag_mem[w_idx][w] == w_tag) begin
            w_hit = 1'b1;
            w_way = WAY_BITS'(w);
         end
      end
   end

   assign idle       = (state_q == IDLE);
   assign rd_hit     = idle && bus.RE && r_hit;
   assign wr_hit     = idle && bus.WE && w_hit;
   assign rd_miss    = idle && bus.RE && !r_hit;
   assign wr_miss    = idle && bus.WE && !w_hit;
   assign fill_done  = (state_q == FILL) && bus.readMemLineValid;
   assign evict_done = (state_q == EVICT) && bus.writeMemAck;

   assign bus.rValid = rd_hit;
   assign bus.wAck   = wr_hit;
   assign bus.busy   = !idle;

   // Read word of the hit way, forwarding the write data on a same-word write hit.
   always_comb begin
      bus.rData = line_mem[r_idx][r_way][int'(r_word) * ARCH_BITS +: ARCH_BITS];
      if (wr_hit && (bus.rAddr == bus.wAddr)) bus.rData = bus.wData;
   end

   cache_plru #(.WAYS(WAYS)) u_plru_rd (
      .plru_cur (plru_q[r_idx]),
      .valid    (valid_q[r_idx]),
      .hit_way  (r_way),
      .plru_next(r_plru_next),
      .victim   (r_victim)
   );

   cache_plru #(.WAYS(WAYS)) u_plru_wr (
      .plru_cur (plru_q[w_idx]),
      .valid    (valid_q[w_idx]),
      .hit_way  (w_way),
      .plru_next(w_plru_next),
      .victim   (w_victim)
   );

   assign bus.readMemAddr  = {miss_line_q, {OFF_BITS{1'b0}}};
   assign bus.writeMemAddr = {tag_mem[m_idx][victim_q], m_idx, {OFF_BITS{1'b0}}};
   assign bus.writeMemLine = line_mem[m_idx][victim_q];

   // Miss engine next state and memory requests. A read miss waits while a
   // write hits so the victim is chosen from up-to-date dirty/PLRU bits.
   always_comb begin
      state_d         = state_q;
      start_miss      = 1'b0;
      miss_line_d     = miss_line_q;
      victim_d        = victim_q;
      bus.readMemReq  = 1'b0;
      bus.writeMemReq = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_miss) begin
               start_miss  = 1'b1;
               miss_line_d = bus.wAddr[ARCH_BITS-1:OFF_BITS];
               victim_d    = w_victim;
            end else if (rd_miss && !wr_hit) begin
               start_miss  = 1'b1;
               miss_line_d = bus.rAddr[ARCH_BITS-1:OFF_BITS];
               victim_d    = r_victim;
            end
            if (start_miss) begin
               state_d = (valid_q[miss_line_d[IDX_BITS-1:0]][victim_d] &&
                          dirty_q[miss_line_d[IDX_BITS-1:0]][victim_d]) ? EVICT : FILL;
            end
         end
         EVICT: begin
            bus.writeMemReq = 1'b1;
            if (bus.writeMemAck) state_d = FILL;
         end
         FILL: begin
            bus.readMemReq = 1'b1;
            if (bus.readMemLineValid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM state and the latched miss context.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state_q     <= IDLE;
         miss_line_q <= '0;
         victim_q    <= '0;
      end else begin
         state_q <= state_d;
         if (start_miss) begin
            miss_line_q <= miss_line_d;
            victim_q    <= victim_d;
         end
      end
   end

   // Valid, dirty and PLRU bookkeeping; a write hit owns the PLRU of its set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         if (wr_hit) begin
            dirty_q[w_idx][w_way] <= 1'b1;
            plru_q[w_idx]         <= w_plru_next;
         end
         if (rd_hit && !(wr_hit && (w_idx == r_idx))) plru_q[r_idx] <= r_plru_next;
         if (evict_done) dirty_q[m_idx][victim_q] <= 1'b0;
         if (fill_done) begin
            valid_q[m_idx][victim_q] <= 1'b1;
            dirty_q[m_idx][victim_q] <= 1'b0;
         end
      end
   end

   // Line and tag storage: word writes on hits, whole-line writes on fills.
   // NOTE: data and tag arrays are not reset; the cleared valid bits make their contents irrelevant.
   always_ff @(posedge clk) begin
      if (wr_hit) line_mem[w_idx][w_way][int'(w_word) * ARCH_BITS +: ARCH_BITS] <= bus.wData;
      if (fill_done) begin
         line_mem[m_idx][victim_q] <= bus.readMemData;
         tag_mem[m_idx][victim_q]  <= m_tag;
      end
   end
endmodule

// File: tb/tb_cache_assoc.sv
// Self-checking bench for cache_assoc (defaults: 32-bit words, 128-bit lines,
// 4 sets, 2 ways) against a line-level model with a sparse backing memory.
module tb_cache_assoc;
   import cache_assoc_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   cache_assoc_if #(.ARCH_BITS(32), .LINE_BITS(128)) bus ();

   cache_assoc #(.ARCH_BITS(32), .CACHE_LINE_SIZE(128), .SETS(4), .WAYS(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Model: per set/way validity, dirtiness, tag and four words; most recently hit way per set.
   bit          m_valid [4][2];
   bit          m_dirty [4][2];
   logic [25:0] m_tag   [4][2];
   logic [31:0] m_data  [4][2][4];
   int          mru     [4];
   logic [31:0] backing [int unsigned];

   logic [31:0]  last_fill_addr;
   logic [31:0]  last_evict_addr;
   logic [127:0] last_evict_line;
   logic [31:0]  rd;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (backing.exists(a)) return backing[a];
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [127:0] mem_line(input logic [31:0] base);
      return {mem_word(base + 32'd12), mem_word(base + 32'd8), mem_word(base + 32'd4), mem_word(base)};
   endfunction

   function automatic int lookup(input int s, input logic [25:0] tg);
      for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == tg) return w;
      return -1;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < 4; s++) begin
         for (int w = 0; w < 2; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
         end
         mru[s] = 1;
      end
   endtask

   task automatic model_install(input logic [31:0] addr, input int v);
      int s;
      logic [31:0] base;
      s    = int'(addr[5:4]);
      base = {addr[31:4], 4'h0};
      m_valid[s][v] = 1'b1;
      m_dirty[s][v] = 1'b0;
      m_tag[s][v]   = addr[31:6];
      for (int k = 0; k < 4; k++) m_data[s][v][k] = mem_word(base + 32'(4 * k));
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One requester access; on a miss it services eviction/fill and retries until it hits.
   task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd_obs);
      int s, w, v, wd, lat;
      logic [25:0]  tg;
      logic [31:0]  base, ev_addr;
      logic [127:0] line;
      s    = int'(addr[5:4]);
      wd   = int'(addr[3:2]);
      tg   = addr[31:6];
      base = {addr[31:4], 4'h0};
      rd_obs = '0;
      for (int attempt = 0; attempt < 2; attempt++) begin
         w = lookup(s, tg);
         @(negedge clk);
         bus.RE = !wr; bus.WE = wr; bus.rAddr = addr; bus.wAddr = addr; bus.wData = wdata;
         #1;
         check("busy_before", bus.busy, 1'b0);
         if (w >= 0) begin
            if (wr) begin
               check("wack_hit", bus.wAck, 1'b1);
               check("rvalid_on_write", bus.rValid, 1'b0);
               m_data[s][w][wd] = wdata;
               m_dirty[s][w] = 1'b1;
            end else begin
               check("rvalid_hit", bus.rValid, 1'b1);
               check("rdata_hit", bus.rData, m_data[s][w][wd]);
               check("wack_on_read", bus.wAck, 1'b0);
            end
            check("no_mem_req_hit", {bus.readMemReq, bus.writeMemReq}, 2'b00);
            rd_obs = bus.rData;
            mru[s] = w;
            @(posedge clk); #1;
            bus.RE = 1'b0; bus.WE = 1'b0;
            return;
         end
         check("miss_no_hit", {bus.rValid, bus.wAck}, 2'b00);
         v = !m_valid[s][0] ? 0 : (!m_valid[s][1] ? 1 : 1 - mru[s]);
         @(posedge clk); #1;
         // Noise on the request side must be ignored while the miss is serviced.
         bus.RE = 1'($urandom_range(0, 1)); bus.WE = 1'($urandom_range(0, 1));
         bus.rAddr = $urandom; bus.wAddr = $urandom & 32'hFFFF_FFFC; bus.wData = $urandom;
         if (m_valid[s][v] && m_dirty[s][v]) begin
            ev_addr = {m_tag[s][v], addr[5:4], 4'h0};
            line = {m_data[s][v][3], m_data[s][v][2], m_data[s][v][1], m_data[s][v][0]};
            lat  = $urandom_range(0, 3);
            for (int i = 0; i <= lat; i++) begin
               check("evict_reqs", {bus.writeMemReq, bus.readMemReq}, 2'b10);
               check("evict_addr", bus.writeMemAddr, ev_addr);
               check("evict_line", bus.writeMemLine, line);
               check("evict_busy_hold", {bus.busy, bus.rValid, bus.wAck}, 3'b100);
               last_evict_addr = bus.writeMemAddr;
               last_evict_line = bus.writeMemLine;
               if (i == lat) bus.writeMemAck = 1'b1;
               @(posedge clk); #1;
               bus.writeMemAck = 1'b0;
            end
            for (int k = 0; k < 4; k++) backing[ev_addr + 32'(4 * k)] = m_data[s][v][k];
            m_dirty[s][v] = 1'b0;
         end
         lat = $urandom_range(0, 3);
         for (int i = 0; i <= lat; i++) begin
            check("fill_reqs", {bus.writeMemReq, bus.readMemReq}, 2'b01);
            check("fill_addr", bus.readMemAddr, base);
            check("fill_busy_hold", {bus.busy, bus.rValid, bus.wAck}, 3'b100);
            last_fill_addr = bus.readMemAddr;
            if (i == lat) begin
               bus.readMemData = mem_line(base);
               bus.readMemLineValid = 1'b1;
               bus.RE = 1'b0; bus.WE = 1'b0;
            end
            @(posedge clk); #1;
            bus.readMemLineValid = 1'b0;
         end
         model_install(addr, v);
         check("idle_after_fill", {bus.busy, bus.readMemReq, bus.writeMemReq}, 3'b000);
      end
   endtask

   initial begin
      bus.RE = 1'b0; bus.WE = 1'b0; bus.rAddr = '0; bus.wAddr = '0; bus.wData = '0;
      bus.readMemData = '0; bus.readMemLineValid = 1'b0; bus.writeMemAck = 1'b0;
      model_reset();
      backing[32'h44] = 32'hDEAD_BEEF;

      // Reset state.
      repeat (3) @(negedge clk);
      check("reset_outputs", {bus.busy, bus.rValid, bus.wAck, bus.readMemReq, bus.writeMemReq}, 5'b0);
      rst = 1'b1;

      // Cold read miss then hit on the filled word.
      last_fill_addr = '1;
      access(1'b0, 32'h40, 32'h0, rd);
      check("cold_fill_addr", last_fill_addr, 32'h40);
      access(1'b0, 32'h44, 32'h0, rd);
      check("cold_read_word1", rd, 32'hDEAD_BEEF);

      // Write hit with same-cycle forwarding.
      @(negedge clk);
      bus.WE = 1'b1; bus.wAddr = 32'h48; bus.wData = 32'h1234_5678;
      bus.RE = 1'b1; bus.rAddr = 32'h48;
      #1;
      check("fwd_wack", bus.wAck, 1'b1);
      check("fwd_rvalid", bus.rValid, 1'b1);
      check("fwd_rdata", bus.rData, 32'h1234_5678);
      m_data[0][0][2] = 32'h1234_5678;
      m_dirty[0][0] = 1'b1;
      mru[0] = 0;
      @(posedge clk); #1;
      bus.WE = 1'b0; bus.RE = 1'b0;

      // Two lines sharing set 0, then dirty eviction of 0x040.
      access(1'b0, 32'h140, 32'h0, rd);
      access(1'b0, 32'h040, 32'h0, rd);
      access(1'b0, 32'h040, 32'h0, rd);
      access(1'b0, 32'h240, 32'h0, rd);
      last_evict_addr = '1;
      last_evict_line = '0;
      access(1'b0, 32'h340, 32'h0, rd);
      check("evict_addr_0x040", last_evict_addr, 32'h40);
      check("evict_word2", last_evict_line[95:64], 32'h1234_5678);

      // Reset in the middle of a fill abandons it.
      @(negedge clk);
      bus.RE = 1'b1; bus.rAddr = 32'h50;
      @(posedge clk); #1;
      bus.RE = 1'b0;
      check("pre_reset_fill_req", bus.readMemReq, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("reset_kills_req", {bus.readMemReq, bus.writeMemReq, bus.busy, bus.rValid, bus.wAck}, 5'b0);
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      last_fill_addr = '1;
      access(1'b0, 32'h40, 32'h0, rd);
      check("post_reset_miss_addr", last_fill_addr, 32'h40);

      // Simultaneous read and write miss: the write is served first.
      @(negedge clk);
      bus.RE = 1'b1; bus.rAddr = 32'h80; bus.WE = 1'b1; bus.wAddr = 32'hC0; bus.wData = 32'hCAFE_F00D;
      #1;
      check("dual_miss_no_ack", {bus.rValid, bus.wAck}, 2'b00);
      @(posedge clk); #1;
      check("dual_miss_req", bus.readMemReq, 1'b1);
      check("dual_miss_write_first", bus.readMemAddr, 32'hC0);
      bus.readMemData = mem_line(32'hC0);
      bus.readMemLineValid = 1'b1;
      bus.RE = 1'b0; bus.WE = 1'b0;
      @(posedge clk); #1;
      bus.readMemLineValid = 1'b0;
      model_install(32'hC0, 1);
      access(1'b1, 32'hC0, 32'hCAFE_F00D, rd);
      access(1'b0, 32'h80, 32'h0, rd);
      access(1'b0, 32'hC0, 32'h0, rd);
      check("dual_miss_readback", rd, 32'hCAFE_F00D);

      // Memory responses outside EVICT/FILL are ignored.
      @(negedge clk);
      bus.readMemData = {4{32'hBAD0_BAD0}};
      bus.readMemLineValid = 1'b1;
      bus.writeMemAck = 1'b1;
      @(posedge clk); #1;
      bus.readMemLineValid = 1'b0;
      bus.writeMemAck = 1'b0;
      check("stray_resp_idle", {bus.busy, bus.readMemReq, bus.writeMemReq}, 3'b000);
      access(1'b0, 32'h84, 32'h0, rd);

      // Randomized reads and writes over a few tags per set.
      for (int n = 0; n < 80; n++) begin
         logic [31:0] a;
         a = {23'd0, 3'($urandom_range(0, 5)), 2'($urandom), 2'($urandom), 2'b00};
         access(($urandom_range(0, 2) == 0), a, $urandom, rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
